systolic_array: RTL and testbench

- 4x4 output-stationary systolic array of IEEE-754 single-precision multiply-accumulate processing elements (PEs).
- Row operands enter from the left edge; column operands enter from the top edge. Operands ripple one PE per clock.
- Each PE accumulates a*b into its own FP32 accumulator.
- The 16 accumulators are exposed in parallel as the matrix-product result for the host datapath.

---
 rtl/systolic_array.sv | 138 +++++++++++++
 tb/tb_systolic_array.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/systolic_array.sv
// 4x4 output-stationary systolic array of FP32 multiply-accumulate PEs.
// Row operands ripple right, column operands ripple down, and each PE owns one accumulator.

module systolic_pe #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [DW-1:0] acc
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [5:0] lzc49(input logic [48:0] v);
        logic [5:0] n;
        logic       done;
        n    = 6'd49;
        done = 1'b0;
        for (int k = 48; k >= 0; k--) begin
            if (!done && v[k]) begin
                n    = 6'(48 - k);
                done = 1'b1;
            end
        end
        return n;
    endfunction

    // Truncating multiply; denormals flush to zero, Inf/NaN collapse to qNaN.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic              s;
        logic [47:0]       p;
        logic [22:0]       f;
        logic signed [9:0] e;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return QNAN;
        if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {s, 31'b0};
        p = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
        if (p[47]) begin
            f = p[46:24];
            e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd126;
        end else begin
            f = p[45:23];
            e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
        end
        if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
        if (e <= 10'sd0)   return {s, 31'b0};
        return {s, e[7:0], f};
    endfunction

    // Truncating add. Zero acts as identity, so an overflowed product can land as Inf;
    // any other exponent-255 operand gives qNaN, which keeps a NaN accumulator sticky.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       big;
        logic [31:0]       sml;
        logic [7:0]        d;
        logic [48:0]       mb;
        logic [48:0]       ms;
        logic [48:0]       sum;
        logic [48:0]       norm;
        logic [5:0]        lz;
        logic signed [9:0] e;
        if (x[30:23] == 8'h00 && y[30:23] == 8'h00) return {x[31] & y[31], 31'b0};
        if (x[30:23] == 8'h00) return y;
        if (y[30:23] == 8'h00) return x;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return QNAN;
        if (y[30:0] > x[30:0]) begin
            big = y;
            sml = x;
        end else begin
            big = x;
            sml = y;
        end
        d = big[30:23] - sml[30:23];
        if (d >= 8'd25) return big;
        // 24 guard bits keep the aligned operand exact, so truncation happens only once.
        mb  = {1'b0, 1'b1, big[22:0], 24'b0};
        ms  = {1'b0, 1'b1, sml[22:0], 24'b0} >> d;
        sum = (big[31] == sml[31]) ? mb + ms : mb - ms;
        if (sum == '0) return 32'h0;
        lz   = lzc49(sum);
        norm = sum << lz;
        e    = $signed({2'b0, big[30:23]}) + 10'sd1 - $signed({4'b0, lz});
        if (e >= 10'sd255) return {big[31], 8'hFF, 23'b0};
        if (e <= 10'sd0)   return {big[31], 31'b0};
        return {big[31], e[7:0], norm[47:25]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= fp_add(acc, fp_mul(a_in, b_in));
        end
    end
endmodule

module systolic_array #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sys_a [N-1:0],
    input  logic [DW-1:0] sys_b [N-1:0],
    output logic [DW-1:0] sys_r [N*N-1:0]
);
    // a_w[i][j] feeds PE(i,j) from the left; b_w[i][j] feeds it from above.
    logic [DW-1:0] a_w [N][N+1];
    logic [DW-1:0] b_w [N+1][N];

    genvar i, j;
    generate
        for (i = 0; i < N; i++) begin : g_edge
            assign a_w[i][0] = sys_a[i];
            assign b_w[0][i] = sys_b[i];
        end
        for (i = 0; i < N; i++) begin : g_row
            for (j = 0; j < N; j++) begin : g_col
                systolic_pe #(.DW(DW)) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .a_in  (a_w[i][j]),
                    .b_in  (b_w[i][j]),
                    .a_out (a_w[i][j+1]),
                    .b_out (b_w[i+1][j]),
                    .acc   (sys_r[N*i+j])
                );
            end
        end
    endgenerate
endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: table of single-PE arithmetic vectors plus
// hand-written reset, wavefront, skewed matrix-product and accumulation sequences.

module tb_systolic_array;
    localparam int N = 4;
    localparam logic [31:0] F0   = 32'h00000000;
    localparam logic [31:0] F1   = 32'h3F800000;
    localparam logic [31:0] F2   = 32'h40000000;
    localparam logic [31:0] F3   = 32'h40400000;
    localparam logic [31:0] F4   = 32'h40800000;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sys_a [N-1:0];
    logic [31:0] sys_b [N-1:0];
    logic [31:0] sys_r [N*N-1:0];
    int          n_cmp = 0;
    int          n_bad = 0;

    systolic_array #(.N(N), .DW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .sys_a (sys_a),
        .sys_b (sys_b),
        .sys_r (sys_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic [31:0] av, input logic [31:0] bv);
        for (int k = 0; k < N; k++) begin
            sys_a[k] = av;
            sys_b[k] = bv;
        end
    endtask

    task automatic do_reset();
        drive_all(F0, F0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    initial begin
        logic [31:0] wf [5];
        int          mx;

        vecs = '{
            '{F2,           F2,           F4,           "2.0x2.0"},
            '{32'h3FC00000, 32'h3FC00000, 32'h40100000, "1.5x1.5"},
            '{32'h7F000000, F2,           32'h7F800000, "overflow"},
            '{QNAN,         F1,           QNAN,         "nan operand"},
            '{32'h00400000, F1,           F0,           "denormal in"},
            '{32'h0D800000, 32'h0D800000, F0,           "underflow"},
            '{32'hC0000000, F3,           32'hC0C00000, "-2.0x3.0"},
            '{F0,           32'h7F800000, QNAN,         "0xinf"},
            '{F1,           F1,           F1,           "1.0x1.0"},
            '{32'h80000000, F2,           F0,           "-0x2.0"}
        };
        wf = '{F0, F1, F2, F3, F4};

        rst = 1'b1;
        drive_all(F0, F0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < N*N; k++) check($sformatf("reset r%0d", k), sys_r[k], F0);

        // Reset mid-stream with non-zero operands still being driven.
        drive_all(F1, F1);
        repeat (3) tick();
        check("prereset r0", sys_r[0], F3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N*N; k++) check($sformatf("midreset r%0d", k), sys_r[k], F0);
        drive_all(F0, F0);
        tick();
        for (int k = 0; k < N*N; k++) check($sformatf("regs cleared r%0d", k), sys_r[k], F0);

        for (int v = 0; v < 10; v++) begin
            do_reset();
            sys_a[0] = vecs[v].a;
            sys_b[0] = vecs[v].b;
            tick();
            check(vecs[v].name, sys_r[0], vecs[v].exp_r);
            check({vecs[v].name, " far pe"}, sys_r[15], F0);
            drive_all(F0, F0);
        end

        // Single PE: a reaches PE(0,1) but meets b=0 there.
        do_reset();
        sys_a[0] = F2;
        sys_b[0] = F2;
        tick();
        drive_all(F0, F0);
        tick();
        for (int k = 0; k < N*N; k++)
            check($sformatf("single r%0d", k), sys_r[k], (k == 0) ? F4 : F0);

        do_reset();
        sys_a[0] = F3;
        sys_b[0] = F1;
        tick();
        sys_a[0] = 32'hC0400000;
        tick();
        check("cancel r0", sys_r[0], F0);

        do_reset();
        sys_a[0] = QNAN;
        sys_b[0] = F1;
        tick();
        drive_all(F1, F1);
        repeat (3) tick();
        check("nan sticky r0", sys_r[0], QNAN);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("nan cleared r0", sys_r[0], F0);

        // Wavefront: PE(i,j) = 4 - max(i,j) after four edges.
        do_reset();
        drive_all(F1, F1);
        repeat (4) tick();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mx = (i > j) ? i : j;
                check($sformatf("wave r%0d", N*i+j), sys_r[N*i+j], wf[4-mx]);
            end
        end

        // Skewed C = A*B with A = all 2.0 and B = 4.0*I.
        do_reset();
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < N; i++)
                sys_a[i] = (t >= i && t - i < N) ? F2 : F0;
            for (int j = 0; j < N; j++)
                sys_b[j] = (t == 2*j) ? F4 : F0;
            tick();
        end
        drive_all(F0, F0);
        for (int k = 0; k < N*N; k++) check($sformatf("matmul r%0d", k), sys_r[k], 32'h41000000);

        do_reset();
        drive_all(F2, F2);
        repeat (5) tick();
        drive_all(F4, F4);
        repeat (5) tick();
        check("sustained r0", sys_r[0], 32'h42C80000);
        check("sustained r15", sys_r[15], 32'h42500000);
        drive_all(F0, F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
